i2c_sensor_reg_slave: RTL and testbench

//  I2C target emulating the sensor's control port: 7-bit device address, 8-bit register

---
 rtl/i2c_sensor_pkg.sv | 35 +++
 rtl/i2c_line_filter.sv | 55 +++++
 rtl/i2c_sensor_reg_slave.sv | 195 +++++++++++++++++++
 tb/tb_i2c_sensor_reg_slave.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sensor_pkg.sv
// Shared definitions for the I2C sensor register target: FSM encoding,
// ACK/NACK bus levels, default device address and state-class helpers.
package i2c_sensor_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_DEV         = 4'd1,
    ST_DEV_ACK     = 4'd2,
    ST_REG         = 4'd3,
    ST_REG_ACK     = 4'd4,
    ST_WR_MSB      = 4'd5,
    ST_WR_MSB_ACK  = 4'd6,
    ST_WR_LSB      = 4'd7,
    ST_WR_LSB_ACK  = 4'd8,
    ST_RD_MSB      = 4'd9,
    ST_RD_MSB_MACK = 4'd10,
    ST_RD_LSB      = 4'd11,
    ST_RD_LSB_MACK = 4'd12
  } state_t;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h5D;

  // States in which the master clocks a byte into the target
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_DEV) || (s == ST_REG) || (s == ST_WR_MSB) || (s == ST_WR_LSB);
  endfunction

  // States in which the target shifts a byte out on SDA
  function automatic logic is_tx_state(input state_t s);
    return (s == ST_RD_MSB) || (s == ST_RD_LSB);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA front end: 2-FF synchroniser, FILT_LEN-deep glitch filter and
// detection of SCL edges plus START/STOP conditions on the filtered levels.
// Idle bus is high, so everything resets to 1 (no false edge after reset).
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // index 0 = SCL, index 1 = SDA
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_lvl;
  logic [1:0]          r_lvl_d;
  logic [FILT_LEN-1:0] r_hist_scl;
  logic [FILT_LEN-1:0] r_hist_sda;

  // Synchronise, keep a sample history and accept a level only when the whole history agrees
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_hist_scl <= '1;
      r_hist_sda <= '1;
      r_lvl      <= '1;
      r_lvl_d    <= '1;
    end else begin
      r_sync1    <= {i_sda, i_scl};
      r_sync2    <= r_sync1;
      r_hist_scl <= {r_hist_scl[FILT_LEN-2:0], r_sync2[0]};
      r_hist_sda <= {r_hist_sda[FILT_LEN-2:0], r_sync2[1]};
      r_lvl_d    <= r_lvl;
      if (&r_hist_scl)       r_lvl[0] <= 1'b1;
      else if (~|r_hist_scl) r_lvl[0] <= 1'b0;
      if (&r_hist_sda)       r_lvl[1] <= 1'b1;
      else if (~|r_hist_sda) r_lvl[1] <= 1'b0;
    end
  end

  assign o_sda      = r_lvl[1];
  assign o_scl_rise =  r_lvl[0] & ~r_lvl_d[0];
  assign o_scl_fall = ~r_lvl[0] &  r_lvl_d[0];
  // SDA moving while SCL has been steadily high
  assign o_start    = r_lvl[0] & r_lvl_d[0] &  r_lvl_d[1] & ~r_lvl[1];
  assign o_stop     = r_lvl[0] & r_lvl_d[0] & ~r_lvl_d[1] &  r_lvl[1];

endmodule

// File: rtl/i2c_sensor_reg_slave.sv
// I2C target emulating a sensor control port: 7-bit device address, 8-bit
// register pointer, 16-bit data MSB first, driving an external register bank.
// Optional feature macro: REG_AUTO_INC_EN -- when defined the pointer
// advances after every completed 16-bit word (write or read), wrapping 0xFF->0x00.
//
// Register-bank strobe protocol: reg_wr_en is a single-cycle strobe with
// reg_addr/reg_wr_data valid in that same cycle; reg_rd_en is a single-cycle
// request for reg_addr and reg_rd_data is captured on the following clock.
// The bank has no back-pressure (always ready).
module i2c_sensor_reg_slave
  import i2c_sensor_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [7:0]  reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        busy,
  output state_t      dbg_state
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_bit_cnt;
  logic        r_byte_done;   // 8th SCL rise of the current byte has been seen
  logic [6:0]  r_shift;       // first seven bits; the 8th comes straight from w_sda
  logic [7:0]  r_msb;
  logic [15:0] r_rd_word;
  logic        r_dev_match;
  logic        r_rw;
  logic        r_mack_nack;
  logic        r_sda_oe;
  logic [7:0]  r_reg_addr;
  logic        r_wr_en;
  logic [15:0] r_wr_data;
  logic        r_rd_en;
  logic        r_busy;

  logic       w_rx, w_tx, w_byte_last, w_byte_end;
  logic [7:0] w_byte;

  assign w_rx        = is_rx_state(r_state);
  assign w_tx        = is_tx_state(r_state);
  assign w_byte      = {r_shift, w_sda};
  assign w_byte_last = w_scl_rise & (w_rx | w_tx) & (r_bit_cnt == 3'd7);
  assign w_byte_end  = w_scl_fall & r_byte_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; START/STOP override every state
  always_comb begin
    w_state_nxt = r_state;
    if (w_start)     w_state_nxt = ST_DEV;
    else if (w_stop) w_state_nxt = ST_IDLE;
    else begin
      case (r_state)
        ST_IDLE:        w_state_nxt = ST_IDLE;
        ST_DEV:         if (w_byte_end) w_state_nxt = r_dev_match ? ST_DEV_ACK : ST_IDLE;
        ST_DEV_ACK:     if (w_scl_fall) w_state_nxt = r_rw ? ST_RD_MSB : ST_REG;
        ST_REG:         if (w_byte_end) w_state_nxt = ST_REG_ACK;
        ST_REG_ACK:     if (w_scl_fall) w_state_nxt = ST_WR_MSB;
        ST_WR_MSB:      if (w_byte_end) w_state_nxt = ST_WR_MSB_ACK;
        ST_WR_MSB_ACK:  if (w_scl_fall) w_state_nxt = ST_WR_LSB;
        ST_WR_LSB:      if (w_byte_end) w_state_nxt = ST_WR_LSB_ACK;
        ST_WR_LSB_ACK:  if (w_scl_fall) w_state_nxt = ST_WR_MSB;
        ST_RD_MSB:      if (w_byte_end) w_state_nxt = ST_RD_MSB_MACK;
        ST_RD_MSB_MACK: if (w_scl_fall) w_state_nxt = (r_mack_nack == I2C_NACK) ? ST_IDLE : ST_RD_LSB;
        ST_RD_LSB:      if (w_byte_end) w_state_nxt = ST_RD_LSB_MACK;
        ST_RD_LSB_MACK: if (w_scl_fall) w_state_nxt = (r_mack_nack == I2C_NACK) ? ST_IDLE : ST_RD_MSB;
        default:        w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: bit capture on SCL rise, SDA drive changes on SCL fall, bank strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
      r_shift     <= '0;
      r_msb       <= '0;
      r_rd_word   <= '0;
      r_dev_match <= 1'b0;
      r_rw        <= 1'b0;
      r_mack_nack <= I2C_NACK;
      r_sda_oe    <= 1'b0;
      r_reg_addr  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
`ifdef REG_AUTO_INC_EN
      // advance only after the strobe cycle so the bank sees the written address
      if (r_wr_en) r_reg_addr <= r_reg_addr + 8'd1;
`endif
      if (w_start || w_stop) begin
        // any partial byte/word is dropped
        r_busy      <= w_start;
        r_sda_oe    <= 1'b0;
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
      end else begin
        if (r_rd_en) begin
          r_rd_word <= reg_rd_data;
          r_sda_oe  <= ~reg_rd_data[15];
        end
        if (w_scl_rise) begin
          if (w_rx || w_tx) begin
            r_shift   <= {r_shift[5:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
          end
          if (r_state == ST_RD_MSB_MACK || r_state == ST_RD_LSB_MACK) r_mack_nack <= w_sda;
          if (w_byte_last) begin
            case (r_state)
              ST_DEV: begin
                r_dev_match <= (w_byte[7:1] == DEV_ADDR);
                r_rw        <= w_byte[0];
              end
              ST_REG:    r_reg_addr <= w_byte;
              ST_WR_MSB: r_msb      <= w_byte;
              ST_WR_LSB: begin
                r_wr_en   <= 1'b1;
                r_wr_data <= {r_msb, w_byte};
              end
`ifdef REG_AUTO_INC_EN
              ST_RD_LSB: r_reg_addr <= r_reg_addr + 8'd1;
`endif
              default: ;
            endcase
          end
        end
        if (w_scl_fall) begin
          if (w_byte_end) r_byte_done <= 1'b0;
          case (r_state)
            ST_DEV, ST_REG, ST_WR_MSB, ST_WR_LSB:
              if (w_byte_end) r_sda_oe <= (w_state_nxt != ST_IDLE);
            ST_DEV_ACK:
              // read: keep ACK low until the fetched word replaces it next clk
              if (r_rw) r_rd_en  <= 1'b1;
              else      r_sda_oe <= 1'b0;
            ST_REG_ACK, ST_WR_MSB_ACK, ST_WR_LSB_ACK:
              r_sda_oe <= 1'b0;
            ST_RD_MSB, ST_RD_LSB: begin
              r_rd_word <= {r_rd_word[14:0], 1'b0};
              r_sda_oe  <= w_byte_end ? 1'b0 : ~r_rd_word[14];
            end
            ST_RD_MSB_MACK:
              r_sda_oe <= (r_mack_nack == I2C_NACK) ? 1'b0 : ~r_rd_word[15];
            ST_RD_LSB_MACK:
              if (r_mack_nack == I2C_ACK) r_rd_en <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign sda_oe      = r_sda_oe;
  assign reg_addr    = r_reg_addr;
  assign reg_wr_en   = r_wr_en;
  assign reg_wr_data = r_wr_data;
  assign reg_rd_en   = r_rd_en;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_i2c_sensor_reg_slave.sv
// Directed bench for i2c_sensor_reg_slave: bus-level master tasks, write
// strobe log checked against an expected queue, final CHECKS/ERRORS report.
// Honours REG_AUTO_INC_EN for the pointer-dependent expectations.
module tb_i2c_sensor_reg_slave;
  import i2c_sensor_pkg::*;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wr_data, reg_rd_data;
  state_t      dbg_state;

  assign sda_line    = m_sda & ~sda_oe;
  assign reg_rd_data = (reg_addr == 8'h35) ? 16'h0020 : 16'h0000;

  i2c_sensor_reg_slave dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (m_scl),
    .sda_in      (sda_line),
    .sda_oe      (sda_oe),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- strobe monitor ----------------
  logic [23:0] wr_log [32];
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_log[wr_cnt[4:0]] = {reg_addr, reg_wr_data};
      wr_cnt = wr_cnt + 1;
    end
    if (reg_rd_en) rd_cnt = rd_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          wr_seen = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_writes(input string tag);
    logic [23:0] e;
    check({tag, "_cnt"}, 32'(wr_cnt - wr_seen), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wr_seen < wr_cnt) check(tag, 32'(wr_log[wr_seen[4:0]]), 32'(e));
      wr_seen++;
    end
    wr_seen = wr_cnt;
  endtask

  // ---------------- bus driver tasks ----------------
  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; wait_q();
      m_scl = 1'b1; wait_q(); wait_q();
      m_scl = 1'b0; wait_q();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    @(negedge clk); ack = sda_line;
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    d = '0;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_q();
      m_scl = 1'b1; wait_q();
      @(negedge clk); d = {d[6:0], sda_line};
      wait_q();
      m_scl = 1'b0;
    end
    wait_q();
    m_sda = mack; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
    m_sda = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       ack;
    logic [7:0] d;
    int         rd0;

    // reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_rd_en", 32'(reg_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // 1: plain write of 0x03C0 to register 0x09
    i2c_start();
    send_byte(8'hBA, ack); check("t1_ack_dev", 32'(ack), 32'd0);
    @(negedge clk); check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h09, ack); check("t1_ack_reg", 32'(ack), 32'd0);
    send_byte(8'h03, ack); check("t1_ack_msb", 32'(ack), 32'd0);
    send_byte(8'hC0, ack); check("t1_ack_lsb", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back({8'h09, 16'h03C0});
    expect_writes("t1_wr");
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);
`ifdef REG_AUTO_INC_EN
    check("t1_reg_addr", 32'(reg_addr), 32'h0A);
`else
    check("t1_reg_addr", 32'(reg_addr), 32'h09);
`endif

    // 3: wrong device address is ignored, next START still works
    rd0 = rd_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("t3_nack_dev", 32'(ack), 32'd1);
    @(negedge clk); check("t3_state", 32'(dbg_state), 32'(ST_IDLE));
    i2c_start();
    send_byte(8'hBA, ack); check("t3_ack_dev2", 32'(ack), 32'd0);
    send_byte(8'h09, ack); check("t3_ack_reg2", 32'(ack), 32'd0);
    i2c_stop();
    expect_writes("t3_wr");
    check("t3_rd_cnt", 32'(rd_cnt - rd0), 32'd0);

    // 4: STOP in the middle of the LSB drops the word
    i2c_start();
    send_byte(8'hBA, ack);
    send_byte(8'h0D, ack);
    send_byte(8'h00, ack);
    send_bits(8'hFF, 4);
    i2c_stop();
    expect_writes("t4_abort");
    @(negedge clk);
    check("t4_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t4_busy", 32'(busy), 32'd0);
    i2c_start();
    send_byte(8'hBA, ack);
    send_byte(8'h0D, ack);
    send_byte(8'h55, ack);
    send_byte(8'hAA, ack); check("t4_ack_lsb", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back({8'h0D, 16'h55AA});
    expect_writes("t4_wr");

    // 5: two words in one write starting at 0xFF
    i2c_start();
    send_byte(8'hBA, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h12, ack);
    send_byte(8'h34, ack);
    send_byte(8'hAB, ack);
    send_byte(8'hCD, ack); check("t5_ack_w1", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back({8'hFF, 16'h1234});
`ifdef REG_AUTO_INC_EN
    exp_q.push_back({8'h00, 16'hABCD});
`else
    exp_q.push_back({8'hFF, 16'hABCD});
`endif
    expect_writes("t5_wr");

    // 2: set pointer, repeated START, read 0x0020, master NACK
    rd0 = rd_cnt;
    i2c_start();
    send_byte(8'hBA, ack);
    send_byte(8'h35, ack); check("t2_ack_reg", 32'(ack), 32'd0);
    i2c_start();
    send_byte(8'hBB, ack); check("t2_ack_rd", 32'(ack), 32'd0);
    recv_byte(1'b0, d); check("t2_msb", 32'(d), 32'h00);
    recv_byte(1'b1, d); check("t2_lsb", 32'(d), 32'h20);
    wait_q();
    @(negedge clk);
    check("t2_sda_released", 32'(sda_oe), 32'd0);
    check("t2_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t2_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
    i2c_stop();
    expect_writes("t2_wr");

    // 6: reset while the target drives read data
    i2c_start();
    send_byte(8'hBB, ack); check("t6_ack_rd", 32'(ack), 32'd0);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    @(negedge clk); check("t6_driving", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (20) @(posedge clk);

    // 6b: single-clock glitches in IDLE must not look like START
    m_sda = 1'b0; @(posedge clk); m_sda = 1'b1;
    repeat (5) @(posedge clk);
    m_scl = 1'b0; @(posedge clk); m_scl = 1'b1;
    repeat (5) @(posedge clk);
    m_sda = 1'b0; m_scl = 1'b0; @(posedge clk); m_sda = 1'b1; m_scl = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_glitch_busy", 32'(busy), 32'd0);
    check("t6_glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    i2c_start();
    send_byte(8'hBA, ack);
    send_byte(8'h01, ack);
    send_byte(8'hBE, ack);
    send_byte(8'hEF, ack); check("t6_ack_after", 32'(ack), 32'd0);
    i2c_stop();
    exp_q.push_back({8'h01, 16'hBEEF});
    expect_writes("t6_wr");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
